// File: rtl/r2fft_pkg.sv
// r2fft_pkg: shared bank states, status encoding and field-width helper for the R2FFT blocks
package r2fft_pkg;
   typedef enum logic [2:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_PROCESSING,
      BANK_READY
   } bank_state_t;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_INPUT_STREAM = 3'd1,
      ST_FULL_BUFFER  = 3'd2,
      ST_RUN_FFT      = 3'd3,
      ST_DONE         = 3'd4
   } status_t;

   function automatic int bw_width(input int dw);
      return $clog2(dw) + 1;
   endfunction
endpackage

// File: rtl/r2fft_varlen_bitrev_counter.sv
// r2fft_varlen_bitrev_counter: sample counter wrapping at 2^len-1 with bit-reversed address over len bits
module r2fft_varlen_bitrev_counter #(
   parameter int N  = 10,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [LW-1:0] len,
   output logic [N-1:0]  addr,
   output logic          last
);
   logic [N-1:0] cnt, rev;
   always_comb
      for (int i = 0; i < N; i++)
         rev[i] = cnt[N-1-i];
   // cnt never exceeds 2^len-1, so reversing all N bits and shifting right leaves len reversed bits
   assign addr = rev >> (N - int'(len));
   assign last = cnt == ({N{1'b1}} >> (N - int'(len)));
   always_ff @(posedge clk or posedge reset)
      if (reset)
         cnt <= '0;
      else if (en)
         cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/r2fft_frame_sequencer.sv
// r2fft_frame_sequencer: ping-pong bank sequencer feeding bit-reversed frames to the FFT core and DMA
module r2fft_frame_sequencer import r2fft_pkg::*; #(
   parameter int FFT_LENGTH_MAX = 1024,
   parameter int FFT_N_MIN      = 3,
   parameter int FFT_DW         = 16,
   parameter int FFT_N          = $clog2(FFT_LENGTH_MAX),
   parameter int BW_W           = bw_width(FFT_DW),
   localparam int LW            = $clog2(FFT_N + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LW-1:0]         cfg_log2len,
   input  logic                  autorun,
   input  logic                  run,
   input  logic                  fin,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FFT_DW-1:0]     in_real,
   input  logic [FFT_DW-1:0]     in_imag,
   output logic                  wr_en,
   output logic                  wr_bank,
   output logic [FFT_N-1:0]      wr_addr,
   output logic [2*FFT_DW-1:0]   wr_data,
   output logic                  fft_start,
   output logic                  fft_bank,
   output logic [LW-1:0]         fft_log2len,
   output logic [BW_W-1:0]       fft_bw,
   input  logic                  fft_done,
   output logic                  done,
   output logic                  dma_bank,
   output logic [2:0]            status,
   output logic [15:0]           stall_count
);
   bank_state_t st [2], st_n [2];
   logic [LW-1:0] len_q [2], len_n [2];
   logic [BW_W-1:0] bw_q [2], bw_n [2];
   logic fill_ptr, proc_ptr, dma_ptr, run_bank, rdy_q;
   logic fill_ptr_n, proc_ptr_n, dma_ptr_n, run_bank_n;
   logic fresh, accept, last, busy, sel;
   logic [LW-1:0] cfg_len, cur_len;
   logic [FFT_N-1:0] addr;
   logic [BW_W-1:0] bw_r, bw_i, s_bw;

   function automatic logic [BW_W-1:0] sig_bits(input logic [FFT_DW-1:0] x);
      logic [FFT_DW-1:0] m;
      sig_bits = '0;
      m = x[FFT_DW-1] ? ~x : x;
      for (int i = 0; i < FFT_DW - 1; i++)
         if (m[i])
            sig_bits = BW_W'(i + 1);
   endfunction

   assign cfg_len = (cfg_log2len < LW'(FFT_N_MIN)) ? LW'(FFT_N_MIN) :
                    (cfg_log2len > LW'(FFT_N)) ? LW'(FFT_N) : cfg_log2len;
   assign fresh = st[fill_ptr] == BANK_EMPTY;
   // the first sample of a frame uses the live config; later samples use the latched length
   assign cur_len = fresh ? cfg_len : len_q[fill_ptr];
   assign in_ready = rdy_q && (fresh || st[fill_ptr] == BANK_FILLING);
   assign accept = in_valid && in_ready;
   assign busy = st[0] == BANK_PROCESSING || st[1] == BANK_PROCESSING;
   assign fft_start = st[proc_ptr] == BANK_FULL && !busy && (autorun || run);
   assign done = st[dma_ptr] == BANK_READY;
   assign dma_bank = dma_ptr;
   assign sel = busy ? run_bank : proc_ptr;
   assign fft_bank = sel;
   assign fft_log2len = len_q[sel];
   assign fft_bw = bw_q[sel];
   assign bw_r = sig_bits(in_real);
   assign bw_i = sig_bits(in_imag);
   assign s_bw = (bw_r > bw_i) ? bw_r : bw_i;

   always_comb begin
      status = (st[0] == BANK_READY || st[1] == BANK_READY) ? ST_DONE :
               busy ? ST_RUN_FFT :
               (st[0] == BANK_FULL || st[1] == BANK_FULL) ? ST_FULL_BUFFER :
               (st[0] == BANK_FILLING || st[1] == BANK_FILLING) ? ST_INPUT_STREAM : ST_IDLE;
   end

   r2fft_varlen_bitrev_counter #(.N(FFT_N), .LW(LW)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .en   (accept),
      .len  (cur_len),
      .addr (addr),
      .last (last)
   );

   // each event acts on a bank in a distinct state, so at most one rule touches a given bank per cycle
   always_comb begin
      st_n = st;
      len_n = len_q;
      bw_n = bw_q;
      fill_ptr_n = fill_ptr;
      proc_ptr_n = proc_ptr;
      dma_ptr_n = dma_ptr;
      run_bank_n = run_bank;
      if (accept) begin
         len_n[fill_ptr] = cur_len;
         bw_n[fill_ptr] = (fresh || s_bw > bw_q[fill_ptr]) ? s_bw : bw_q[fill_ptr];
         st_n[fill_ptr] = last ? BANK_FULL : BANK_FILLING;
         fill_ptr_n = fill_ptr ^ last;
      end
      if (fft_start) begin
         st_n[proc_ptr] = BANK_PROCESSING;
         proc_ptr_n = ~proc_ptr;
         run_bank_n = proc_ptr;
      end
      if (fft_done && busy)
         st_n[run_bank] = BANK_READY;
      if (fin && done) begin
         st_n[dma_ptr] = BANK_EMPTY;
         dma_ptr_n = ~dma_ptr;
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= '{default: BANK_EMPTY};
         len_q <= '{default: '0};
         bw_q <= '{default: '0};
         fill_ptr <= 1'b0;
         proc_ptr <= 1'b0;
         dma_ptr <= 1'b0;
         run_bank <= 1'b0;
         rdy_q <= 1'b0;
         wr_en <= 1'b0;
         wr_bank <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         stall_count <= '0;
      end else begin
         st <= st_n;
         len_q <= len_n;
         bw_q <= bw_n;
         fill_ptr <= fill_ptr_n;
         proc_ptr <= proc_ptr_n;
         dma_ptr <= dma_ptr_n;
         run_bank <= run_bank_n;
         rdy_q <= 1'b1;
         wr_en <= accept;
         if (accept) begin
            wr_bank <= fill_ptr;
            wr_addr <= addr;
            wr_data <= {in_imag, in_real};
         end
         if (in_valid && !in_ready && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
endmodule
